wrr_arbiter: RTL and testbench
==============================

WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, number of requestors (legal range 2..32).
REQ-002 The block SHALL have parameter WW, default 4, width of each per-requestor weight field.
REQ-003 The block SHALL have port clk, input, 1, clock.
REQ-004 The block SHALL have port rst_an, input, 1, reset: asynchronous, active-low.
REQ-005 The block SHALL have port req, input, N, per-requestor request level.
REQ-006 The block SHALL have port weight, input, N*WW, quasi-static weights; field i is weight[i*WW +: WW].
REQ-007 The block SHALL have port done, input, 1, one-cycle pulse meaning the current owner completed one transfer.
REQ-008 The block SHALL have port grant, output, N, registered one-hot grant.
REQ-009 The block SHALL have port grant_id, output, max(1,$clog2(N)), registered index of the owner; it is valid only while busy is 1.
REQ-010 The block SHALL have port busy, output, 1, registered; equals |grant.

Function
REQ-011 FSM states SHALL be IDLE and OWNED.
REQ-012 IDLE: if |req, select winner and go to OWNED; grant is asserted the cycle after req is sampled (latency 1).
REQ-013 Winner SHALL be the lowest index i >= ptr with req[i] set; if none, the lowest index with req[i] set (masked/unmasked priority pair).
REQ-014 On entering OWNED, credit SHALL load with weight[winner], and a weight of 0 is treated as 1.
REQ-015 OWNED: grant, grant_id and credit SHALL hold until done is 1 or req[owner] is 0.
REQ-016 On done with credit > 1 and req[owner] still 1, credit SHALL decrement and grant SHALL stay asserted with no bubble.
REQ-017 On done with credit == 1, or on req[owner] low, grant SHALL drop next cycle, ptr SHALL become (owner+1) mod N, and the FSM SHALL return to IDLE.
REQ-018 The IDLE-return cycle SHALL be a mandatory one-cycle bubble: grant is 0 for at least one cycle between different owners.
REQ-019 If done and req[owner]==0 occur in the same cycle, the behaviour of REQ-017 SHALL apply.
REQ-020 done while in IDLE SHALL be ignored.
REQ-021 ptr wrap SHALL satisfy owner N-1 -> ptr 0.
REQ-022 weight changes SHALL take effect only at the next credit load.
REQ-023 The arbiter SHALL guarantee no starvation: any held req is granted within (N-1)*(2^WW) transfers plus N bubbles.

Reset
REQ-024 Reset SHALL set grant=0, grant_id=0, busy=0, ptr=0, credit=0, and state IDLE.
REQ-025 Reset asserted mid-OWNED SHALL clear the grant immediately (asynchronously), and the first post-reset winner SHALL be chosen from ptr=0.

Configuration
REQ-026 With WRR_ARBITER_LOCK_EN defined, input lock (1 bit) SHALL exist: while lock=1 in OWNED, done SHALL NOT decrement credit and the grant is never released by credit exhaustion; release happens only on req[owner] low.
REQ-027 Without WRR_ARBITER_LOCK_EN, the lock port SHALL be absent and the behaviour SHALL be as REQ-011..023.

Structure
REQ-028 The shared package arb_pkg SHALL hold the FSM state enum and the function for the onehot-to-index conversion.
REQ-029 One sub-module, arb_prio_pick, SHALL be used: a combinational lowest-index priority picker instantiated twice (masked and unmasked).
REQ-030 No other sub-modules SHALL be used.

Verification
REQ-031 Weights all 1, N=4, req=4'b1111 held: grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001 with done pulsed each grant cycle.
REQ-032 weight0=3, weight1=1, req=4'b0011, done every cycle: grant0 for 3 consecutive cycles, then bubble, then grant1 for 1 cycle, then bubble, then grant0.
REQ-033 Owner 2 with credit 3 drops req2 after 1 done: grant falls next cycle, ptr=3, and req=4'b0101 then grants 0.
REQ-034 ptr=3, req=4'b0011: unmasked fallback grants requestor 0, ptr wraps, and grant_id=0.
REQ-035 rst_an low while owner=1 busy: grant=0 same cycle; after release, req=4'b0110 grants 1.
REQ-036 With WRR_ARBITER_LOCK_EN, lock=1, weight=1, and 5 done pulses: grant holds throughout; dropping req releases it next cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // Sized for the widest legal requestor count (32); callers zero-extend and truncate.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational lowest-index priority picker: isolates the lowest set bit of req.
module arb_prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  assign gnt = req & (~req + 1'b1);
  assign any = |req;

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, per-owner transfer credit, one-cycle bubble between owners.
// Optional WRR_ARBITER_LOCK_EN adds a lock input that stops credit consumption while the owner holds it.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int WW  = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_an,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            done,
`ifdef WRR_ARBITER_LOCK_EN
  input  logic            lock,
`endif
  output logic [N-1:0]    grant,
  output logic [IDW-1:0]  grant_id,
  output logic            busy
);

  arb_state_e     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [WW-1:0]  credit_q, credit_d;

  logic [N-1:0]   mask, pick_m, pick_u, winner;
  logic           any_m, any_u, lock_on, owner_req, release_own;
  logic [IDW-1:0] win_idx;
  logic [WW-1:0]  weight_arr [N];

`ifdef WRR_ARBITER_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  for (genvar i = 0; i < N; i++) begin : g_req
    assign mask[i]       = (IDW'(i) >= ptr_q);
    assign weight_arr[i] = weight[i*WW +: WW];
  end

  arb_prio_pick #(.N(N)) u_pick_masked (
    .req (req & mask),
    .gnt (pick_m),
    .any (any_m)
  );

  arb_prio_pick #(.N(N)) u_pick_unmasked (
    .req (req),
    .gnt (pick_u),
    .any (any_u)
  );

  // Requestors at or above ptr win first; the unmasked pick handles wrap-around.
  assign winner    = any_m ? pick_m : pick_u;
  assign win_idx   = IDW'(onehot_to_idx(32'(winner)));
  assign owner_req = req[grant_id_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    credit_d    = credit_q;
    release_own = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_u) begin
          state_d    = ST_OWNED;
          grant_d    = winner;
          grant_id_d = win_idx;
          credit_d   = (weight_arr[win_idx] == '0) ? WW'(1) : weight_arr[win_idx];
        end
      end
      ST_OWNED: begin
        release_own = !owner_req || (done && !lock_on && credit_q <= WW'(1));
        if (release_own) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          credit_d = '0;
          ptr_d    = (grant_id_q == IDW'(N-1)) ? '0 : grant_id_q + 1'b1;
        end else if (done && !lock_on) begin
          credit_d = credit_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      credit_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      credit_q   <= credit_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = |grant_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic            clk = 1'b0;
  logic            rst_an = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*WW-1:0] weight = '0;
  logic            done = 1'b0;
  logic            lock = 1'b0;
  logic [N-1:0]    grant;
  logic [1:0]      grant_id;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: current owner (-1 when idle), remaining transfers, round-robin start.
  int m_owner  = -1;
  int m_credit = 0;
  int m_ptr    = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk      (clk),
    .rst_an   (rst_an),
    .req      (req),
    .weight   (weight),
    .done     (done),
`ifdef WRR_ARBITER_LOCK_EN
    .lock     (lock),
`endif
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy)
  );

  task automatic set_weight(input int i, input int v);
    weight[i*WW +: WW] = WW'(v);
  endtask

  function automatic int eff_weight(input int i);
    int v;
    v = int'(weight[i*WW +: WW]);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic mdl_reset();
    m_owner  = -1;
    m_credit = 0;
    m_ptr    = 0;
  endtask

  task automatic mdl_tick();
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req[j]) begin
          m_owner  = j;
          m_credit = eff_weight(j);
          break;
        end
      end
    end else if (!req[m_owner] || (done && !lock && m_credit == 1)) begin
      m_ptr    = (m_owner + 1) % N;
      m_owner  = -1;
      m_credit = 0;
    end else if (done && !lock) begin
      m_credit = m_credit - 1;
    end
  endtask

  function automatic logic [N-1:0] mdl_grant();
    return (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endfunction

  task automatic cycle();
    mdl_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_an = 1'b0;
    req    = '0;
    done   = 1'b0;
    lock   = 1'b0;
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    rst_an = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    req = 4'b1111;
    @(posedge clk);
    #1;
    n_cmp++;
    if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_hold_grant: got %b expected 0000", grant); end
    do_reset();
  endtask

  task automatic test_equal_weights();
    logic [3:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    for (int i = 0; i < N; i++) set_weight(i, 1);
    req  = 4'b1111;
    done = 1'b1;
    for (int c = 0; c < 9; c++) begin
      cycle();
      n_cmp++;
      if (grant !== exp_seq[c]) begin
        n_err++;
        $display("FAIL equal_weights cycle %0d: got %b expected %b", c, grant, exp_seq[c]);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_weighted();
    logic [3:0] exp_seq [7];
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
    do_reset();
    set_weight(0, 3);
    set_weight(1, 1);
    req  = 4'b0011;
    done = 1'b1;
    for (int c = 0; c < 7; c++) begin
      cycle();
      n_cmp++;
      if (grant !== exp_seq[c]) begin
        n_err++;
        $display("FAIL weighted cycle %0d: got %b expected %b", c, grant, exp_seq[c]);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_drop_req();
    do_reset();
    set_weight(2, 3);
    req = 4'b0100;
    cycle();
    n_cmp++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      n_err++; $display("FAIL drop_req_owner: got %b/%0d expected 0100/2", grant, grant_id);
    end
    done = 1'b1;
    cycle();
    n_cmp++;
    if (grant !== 4'b0100) begin n_err++; $display("FAIL drop_req_after_done: got %b expected 0100", grant); end
    done = 1'b0;
    req  = 4'b0000;
    cycle();
    n_cmp++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL drop_req_release: got %b busy %b expected 0000 busy 0", grant, busy);
    end
    req = 4'b0101;
    cycle();
    n_cmp++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      n_err++; $display("FAIL drop_req_next: got %b/%0d expected 0001/0", grant, grant_id);
    end
    req = 4'b0000;
    cycle();
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    set_weight(2, 1);
    set_weight(3, 1);
    req  = 4'b1000;
    done = 1'b1;
    cycle();
    n_cmp++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      n_err++; $display("FAIL wrap_owner3: got %b/%0d expected 1000/3", grant, grant_id);
    end
    req = 4'b0011;
    cycle();
    cycle();
    n_cmp++;
    if (grant !== 4'b0001 || grant_id !== 2'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL wrap_grant0: got %b/%0d busy %b expected 0001/0 busy 1", grant, grant_id, busy);
    end
    done = 1'b0;
    req  = 4'b0000;
    cycle();
  endtask

  task automatic test_reset_mid_owned();
    do_reset();
    req = 4'b0010;
    cycle();
    n_cmp++;
    if (grant !== 4'b0010) begin n_err++; $display("FAIL midrst_pre: got %b expected 0010", grant); end
    #2;
    rst_an = 1'b0;
    mdl_reset();
    #1;
    n_cmp++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_async: got %b busy %b expected 0000 busy 0", grant, busy);
    end
    @(negedge clk);
    rst_an = 1'b1;
    req    = 4'b0110;
    cycle();
    n_cmp++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      n_err++; $display("FAIL midrst_after: got %b/%0d expected 0010/1", grant, grant_id);
    end
    req = 4'b0000;
    cycle();
  endtask

`ifdef WRR_ARBITER_LOCK_EN
  task automatic test_lock();
    do_reset();
    set_weight(0, 1);
    req  = 4'b0001;
    lock = 1'b1;
    cycle();
    done = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_cmp++;
      if (grant !== 4'b0001) begin n_err++; $display("FAIL lock_hold cycle %0d: got %b expected 0001", c, grant); end
    end
    done = 1'b0;
    req  = 4'b0000;
    cycle();
    n_cmp++;
    if (grant !== 4'b0000) begin n_err++; $display("FAIL lock_release: got %b expected 0000", grant); end
    lock = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] exp_g;
    do_reset();
    for (int i = 0; i < N; i++) set_weight(i, $urandom_range(0, 3));
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 15) req[i] = ~req[i];
      end
      done = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) set_weight($urandom_range(0, N-1), $urandom_range(0, 15));
      cycle();
      exp_g = mdl_grant();
      n_cmp++;
      if (grant !== exp_g) begin
        n_err++; $display("FAIL random_grant cycle %0d: got %b expected %b", c, grant, exp_g);
      end
      n_cmp++;
      if (busy !== (m_owner >= 0)) begin
        n_err++; $display("FAIL random_busy cycle %0d: got %b expected %b", c, busy, (m_owner >= 0));
      end
      if (m_owner >= 0) begin
        n_cmp++;
        if (int'(grant_id) != m_owner) begin
          n_err++; $display("FAIL random_grant_id cycle %0d: got %0d expected %0d", c, grant_id, m_owner);
        end
      end
    end
    req  = '0;
    done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equal_weights();
    test_weighted();
    test_drop_req();
    test_ptr_wrap();
    test_reset_mid_owned();
`ifdef WRR_ARBITER_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
